// File: rtl/hazard_controller_pkg.sv
// Shared pipeline-control definitions: FSM state encoding and the register specifier width.
package hazard_controller_pkg;

  localparam int PIPE_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and data-memory waits.
// Control outputs are combinational from the registered FSM state and the current hazard inputs.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W        = PIPE_REG_ADDR_W,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MAX_MEM_WAIT      = 64,
  parameter int STAT_W            = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rt,
  input  logic                  IF_ID_UsesRt,
  input  logic [REG_ADDR_W-1:0] ID_EXE_Rt,
  input  logic                  ID_EXE_MemRead,
  input  logic                  branch_taken,
  input  logic                  EXE_MEM_MemAccess,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  IF_ID_write,
  output logic                  IF_ID_flush,
  output logic                  ID_EXE_bubble,
  output logic                  ID_EXE_write,
  output logic                  EXE_MEM_write,
  output logic                  MEM_WB_bubble,
  output logic [STAT_W-1:0]     stall_count,
  output logic                  mem_timeout
);

  localparam int                WAIT_W     = $clog2(MAX_MEM_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_MEM_WAIT - 1);
  localparam logic [2:0]        LD_RELOAD  = 3'(LOAD_STALL_CYCLES - 1);

  state_t            state, next_state, eff_state;
  logic [2:0]        ld_cnt, ld_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_inc, wait_clr;
  logic              memwait, loaduse;

  assign memwait = EXE_MEM_MemAccess & mem_busy;
  assign loaduse = ID_EXE_MemRead && (ID_EXE_Rt != '0) &&
                   ((ID_EXE_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EXE_Rt == IF_ID_Rt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      ld_cnt <= '0;
    end else begin
      state  <= next_state;
      ld_cnt <= ld_next;
    end
  end

  always_comb begin
    pc_write      = 1'b1;
    IF_ID_write   = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EXE_bubble = 1'b0;
    ID_EXE_write  = 1'b1;
    EXE_MEM_write = 1'b1;
    MEM_WB_bubble = 1'b0;
    next_state    = RUN;
    ld_next       = ld_cnt;
    wait_inc      = 1'b0;
    wait_clr      = 1'b0;
    // Leaving a memory wait resumes whatever load stall it interrupted.
    eff_state     = state;
    if (state == MEM_WAIT) begin
      eff_state = (ld_cnt != 3'd0) ? LOAD_STALL : RUN;
    end

    if (memwait) begin
      pc_write      = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EXE_write  = 1'b0;
      EXE_MEM_write = 1'b0;
      MEM_WB_bubble = 1'b1;
      next_state    = MEM_WAIT;
      wait_inc      = (state == MEM_WAIT);
    end else begin
      wait_clr = 1'b1;
      if (branch_taken) begin
        IF_ID_flush   = 1'b1;
        ID_EXE_bubble = 1'b1;
        ld_next       = 3'd0;
      end else if (eff_state == LOAD_STALL) begin
        pc_write      = 1'b0;
        IF_ID_write   = 1'b0;
        ID_EXE_bubble = 1'b1;
        ld_next       = ld_cnt - 3'd1;
        next_state    = (ld_next != 3'd0) ? LOAD_STALL : RUN;
      end else if (loaduse) begin
        pc_write      = 1'b0;
        IF_ID_write   = 1'b0;
        ID_EXE_bubble = 1'b1;
        ld_next       = LD_RELOAD;
        next_state    = (LD_RELOAD != 3'd0) ? LOAD_STALL : RUN;
      end
    end

    if (rst) begin
      pc_write      = 1'b0;
      IF_ID_write   = 1'b0;
      IF_ID_flush   = 1'b0;
      ID_EXE_bubble = 1'b0;
      ID_EXE_write  = 1'b0;
      EXE_MEM_write = 1'b0;
      MEM_WB_bubble = 1'b0;
    end
  end

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wait_inc),
    .clr   (wait_clr),
    .count (wait_cnt)
  );

  sat_counter #(.W(STAT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~pc_write),
    .clr   (1'b0),
    .count (stall_count)
  );

  // Sticky until reset; the pipeline keeps stalling regardless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_timeout <= 1'b0;
    end else if (wait_inc && (wait_cnt >= WAIT_LIMIT)) begin
      mem_timeout <= 1'b1;
    end
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline sequencing controller for the 5-stage MIPS datapath; it works alongside the forwarding unit.
- Resolves the hazards forwarding cannot cover: load-use, taken-branch flush and multi-cycle data-memory waits.
- Drives the PC and pipeline-register write enables, flushes and bubbles through a small FSM with stall counters.
- Keeps a saturating stall-cycle statistic and a sticky memory-timeout error.

Parameters:
REG_ADDR_W, 5, register specifier width
LOAD_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (1..7)
MAX_MEM_WAIT, 64, MEM_WAIT cycles before mem_timeout is set
STAT_W, 16, stall_count width

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous active-high reset
IF_ID_Rs  in  REG_ADDR_W  rs of instruction in ID
IF_ID_Rt  in  REG_ADDR_W  rt of instruction in ID
IF_ID_UsesRt  in  1  ID instruction reads rt
ID_EXE_Rt  in  REG_ADDR_W  destination of instruction in EXE
ID_EXE_MemRead  in  1  EXE instruction is a load
branch_taken  in  1  branch/jump resolved taken in EXE
EXE_MEM_MemAccess  in  1  MEM-stage instruction accesses data memory
mem_busy  in  1  data memory not ready this cycle
pc_write  out  1  PC update enable
IF_ID_write  out  1  IF/ID register enable
IF_ID_flush  out  1  clear IF/ID to NOP
ID_EXE_bubble  out  1  load NOP into ID/EXE
ID_EXE_write  out  1  ID/EXE register enable
EXE_MEM_write  out  1  EXE/MEM register enable
MEM_WB_bubble  out  1  load NOP into MEM/WB
stall_count  out  STAT_W  saturating count of cycles with pc_write=0
mem_timeout  out  1  sticky: wait exceeded MAX_MEM_WAIT

Behaviour:
- States: RUN, LOAD_STALL, MEM_WAIT. State and counters are registered; control outputs are combinational from state and current inputs.
- Reset (rst=1, asynchronous):
  - state=RUN, counters=0, mem_timeout=0, stall_count=0.
  - pc_write, IF_ID_write, ID_EXE_write and EXE_MEM_write are forced 0.
  - IF_ID_flush, ID_EXE_bubble and MEM_WB_bubble are forced 0.
- Default outputs in RUN with no hazard: all writes=1, flush/bubbles=0.
- memwait = EXE_MEM_MemAccess & mem_busy. loaduse = ID_EXE_MemRead & ID_EXE_Rt!=0 & (ID_EXE_Rt==IF_ID_Rs | (IF_ID_UsesRt & ID_EXE_Rt==IF_ID_Rt)).
- Priority, highest first: memwait > branch_taken > loaduse.
- memwait, any state:
  - Same cycle: pc_write, IF_ID_write, ID_EXE_write and EXE_MEM_write = 0; MEM_WB_bubble = 1.
  - Next state MEM_WAIT; the wait counter increments each MEM_WAIT cycle.
  - The first cycle with mem_busy=0 restores defaults and returns to RUN; the wait counter clears.
  - If the counter reaches MAX_MEM_WAIT, mem_timeout is set; it clears only on rst. Stalling continues regardless.
  - A LOAD_STALL interrupted by memwait resumes with its remaining count afterwards.
- branch_taken, no memwait:
  - IF_ID_flush=1 and ID_EXE_bubble=1; pc_write=1 loads the target.
  - Any LOAD_STALL is aborted (counter cleared, next state RUN).
  - No stall is counted.
- loaduse in RUN:
  - Same cycle: pc_write=0, IF_ID_write=0, ID_EXE_bubble=1.
  - If LOAD_STALL_CYCLES>1, enter LOAD_STALL with counter=LOAD_STALL_CYCLES-1. Each LOAD_STALL cycle holds the same outputs and decrements; at 0 return to RUN.
  - loaduse is not re-evaluated while in LOAD_STALL.
- stall_count increments on each non-reset cycle with pc_write=0 and saturates at all-ones.
- Register 0 never creates a load-use hazard.

Decomposition:
- Shared package (pipeline control): FSM state encoding (RUN=2'b00, LOAD_STALL=2'b01, MEM_WAIT=2'b10) and REG_ADDR_W.
- One sub-module is natural: sat_counter (parameterised width, inc, clear, saturating). It is used for stall_count and the wait counter.

Test Plan:
- Load-use: ID_EXE_MemRead=1, ID_EXE_Rt=5, IF_ID_Rs=5 for 1 cycle, LOAD_STALL_CYCLES=1 -> that cycle pc_write=0, IF_ID_write=0, ID_EXE_bubble=1; next cycle defaults; stall_count=1.
- Rt-only and r0 cases:
  - ID_EXE_Rt=7, IF_ID_Rt=7, IF_ID_UsesRt=0 -> no stall.
  - Same with UsesRt=1 -> stall.
  - ID_EXE_Rt=0 matching IF_ID_Rs=0 -> no stall.
- Branch vs load-use: branch_taken=1 with loaduse true -> IF_ID_flush=1, ID_EXE_bubble=1, pc_write=1, stall_count unchanged.
- LOAD_STALL_CYCLES=3 with branch_taken in the second stall cycle -> flush that cycle; next cycle RUN defaults.
- Memory wait: EXE_MEM_MemAccess=1, mem_busy=1 for 4 cycles -> all writes 0 and MEM_WB_bubble=1 for 4 cycles; defaults on cycle 5; stall_count=4.
- Timeout and reset:
  - MAX_MEM_WAIT=8 with mem_busy held 10 cycles -> mem_timeout=1 after 8 MEM_WAIT cycles, still stalling.
  - Assert rst mid-wait -> immediately state RUN, all outputs 0, mem_timeout=0, stall_count=0.
